modulo_controle_ataque: RTL and testbench
=========================================

MODULO_CONTROLE_ATAQUE -- requirements
Module: modulo_controle_ataque

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning the number of consecutive stable synchronized samples needed to accept a button level change (range 2..2^20).
REQ-002 SHALL have port clk, input, 1 bit: single system clock, rising edge.
REQ-003 SHALL have port clr, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port button_confirmation, input, 1 bit: raw confirm pushbutton, pressed = 1, asynchronous to clk.
REQ-005 SHALL have port button_clear, input, 1 bit: raw clear pushbutton, pressed = 1, asynchronous to clk.
REQ-006 SHALL have port coord_at, input, 6 bits: [5:3] line 1..7, [2:0] column 1..5.
REQ-007 SHALL have port m_po, input, 35 bits: ship-position matrix, 1 = ship cell.
REQ-008 SHALL have port m_at_out, output, 35 bits: attacked-cell matrix, 1 = attacked; feeds the attack-matrix LED multiplexer.
REQ-009 SHALL have port status, output, 2 bits: 00 none, 01 water, 10 hit, 11 invalid or repeated; feeds the 7-segment status digit.
REQ-010 SHALL have port at_wr, output, 1 bit: single-cycle commit strobe.
REQ-011 SHALL have port at_idx, output, 6 bits: cell index of the last commit.
REQ-012 SHALL have port hit_count, output, 6 bits: ship cells hit.
REQ-013 SHALL have port attack_count, output, 6 bits: valid attacks committed.
REQ-014 SHALL have port game_over, output, 1 bit: all ship cells hit.

Function
REQ-015 Each button SHALL pass through a 2-flop synchronizer, then a debouncer whose level changes only after DEBOUNCE_CYCLES consecutive equal samples.
REQ-016 A confirm event SHALL be a one-cycle pulse on the 0->1 transition of the debounced confirm level.
REQ-017 Cell index SHALL be idx = (line-1)*5 + (col-1); matrix bit used = 34 - idx (line 1, col 1 = bit 34).
REQ-018 A coordinate SHALL be valid only for line 1..7 and column 1..5; any other value is invalid.
REQ-019 FSM states SHALL be IDLE, CHECK, COMMIT, WAIT_RELEASE, GAME_OVER.
REQ-020 IDLE: on a confirm pulse, latch coord_at and go to CHECK; otherwise stay.
REQ-021 CHECK (1 cycle): if the latched coordinate is invalid, or its m_at_out bit is already 1, set status = 11, leave all counters unchanged, and go to WAIT_RELEASE; otherwise go to COMMIT.
REQ-022 COMMIT (1 cycle) SHALL perform the following:
- assert at_wr = 1 and drive at_idx = idx;
- set the m_at_out bit;
- increment attack_count;
- if the m_po bit is 1: status = 10 and hit_count += 1; else status = 01.
All registered updates SHALL take effect at the edge leaving COMMIT.
REQ-023 From COMMIT, SHALL go to GAME_OVER if (m_po & ~m_at_next) == 0 and m_po != 0; otherwise go to WAIT_RELEASE.
REQ-024 WAIT_RELEASE: return to IDLE when the debounced confirm level is 0; a held button SHALL never produce a second attack.
REQ-025 GAME_OVER: game_over = 1; confirm pulses are ignored; status and matrices hold.
REQ-026 Latency SHALL be: confirm pulse at edge k -> CHECK in cycle k+1 -> COMMIT in cycle k+2 -> outputs updated after edge k+3.
REQ-027 status SHALL hold its value until the next CHECK/COMMIT result or until a clear.
REQ-028 A debounced button_clear rising edge SHALL act as a synchronous clear in any state, with priority over a simultaneous confirm pulse:
- m_at_out = 0, counters = 0, status = 00, game_over = 0;
- next state IDLE.
REQ-029 Counters SHALL saturate at 35; coord_at changes outside IDLE SHALL have no effect.
REQ-030 m_po SHALL be treated as static during play; it is sampled only in COMMIT and in the game-over test.

Reset
REQ-031 With clr = 0 asynchronously, the block SHALL set:
- FSM = IDLE; m_at_out = 0, status = 00, at_wr = 0, at_idx = 0, hit_count = 0, attack_count = 0, game_over = 0;
- synchronizers and debouncers = 0.
REQ-032 Reset asserted mid-operation, including during COMMIT, SHALL abort without any partial update; operation resumes from IDLE on the first edge after clr = 1.

Verification
REQ-033 Valid miss: m_po = 0, coord_at = 6'b001_001, press -> exactly one at_wr pulse, at_idx = 0, m_at_out[34] = 1, status = 01, attack_count = 1, hit_count = 0.
REQ-034 Valid hit: m_po[0] = 1, coord_at = 6'b111_101, press -> at_idx = 34, m_at_out[0] = 1, status = 10, hit_count = 1.
REQ-035 Invalid and repeat: coord_at = 6'b000_011, or any already-attacked cell -> status = 11, no at_wr pulse, counters unchanged.
REQ-036 Bounce: 1/0 toggling shorter than DEBOUNCE_CYCLES followed by one steady 200-cycle hold -> exactly one commit, and no second commit while the button is held.
REQ-037 Game over: m_po with 2 ship bits, attack both cells -> game_over = 1 after the second COMMIT; further presses give no at_wr; button_clear -> all outputs return to reset values and the FSM is in IDLE.
REQ-038 Reset during COMMIT: clr = 0 in cycle k+2 -> m_at_out = 0 and no counter change.

Source files
------------

// File: rtl/modulo_controle_ataque.sv
// Attack controller: debounced confirm/clear buttons drive a one-shot attack FSM over a 7x5 board.
// Latency: confirm pulse at edge k -> CHECK k+1 -> COMMIT k+2 -> registered outputs after edge k+3.
// Backpressure: none; a held confirm parks the FSM in WAIT_RELEASE until the debounced level drops.
module modulo_controle_ataque #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        button_confirmation,
    input  logic        button_clear,
    input  logic [5:0]  coord_at,
    input  logic [34:0] m_po,
    output logic [34:0] m_at_out,
    output logic [1:0]  status,
    output logic        at_wr,
    output logic [5:0]  at_idx,
    output logic [5:0]  hit_count,
    output logic [5:0]  attack_count,
    output logic        game_over
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [5:0]    CNT_MAX  = 6'd35;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        COMMIT,
        WAIT_RELEASE,
        GAME_OVER
    } state_t;

    state_t state, state_nxt;

    // bit 0 = confirm, bit 1 = clear
    logic [1:0]    btn_raw, sync_a, sync_b, db_lvl, db_lvl_q;
    logic [CW-1:0] db_cnt [2];
    logic          conf_pulse, clr_pulse;

    assign btn_raw = {button_clear, button_confirmation};

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync_a   <= '0;
            sync_b   <= '0;
            db_lvl   <= '0;
            db_lvl_q <= '0;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            sync_a   <= btn_raw;
            sync_b   <= sync_a;
            db_lvl_q <= db_lvl;
            for (int i = 0; i < 2; i++) begin
                if (sync_b[i] == db_lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_LAST) begin
                    db_lvl[i] <= sync_b[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign conf_pulse = db_lvl[0] & ~db_lvl_q[0];
    assign clr_pulse  = db_lvl[1] & ~db_lvl_q[1];

    logic [5:0]  coord_q;
    logic [2:0]  line_q, col_q;
    logic        coord_valid, cell_taken, cell_hit, all_sunk;
    logic [5:0]  cell_idx;
    logic [34:0] cell_mask, m_at_next;

    assign line_q      = coord_q[5:3];
    assign col_q       = coord_q[2:0];
    assign coord_valid = (line_q != 3'd0) && (col_q != 3'd0) && (col_q <= 3'd5);
    assign cell_idx    = ({3'd0, line_q} - 6'd1) * 6'd5 + {3'd0, col_q} - 6'd1;
    // Invalid coordinates produce an empty mask so they can never touch the matrix.
    assign cell_mask   = coord_valid ? (35'd1 << (6'd34 - cell_idx)) : '0;
    assign m_at_next   = m_at_out | cell_mask;
    assign cell_taken  = |(m_at_out & cell_mask);
    assign cell_hit    = |(m_po & cell_mask);
    assign all_sunk    = (m_po != '0) && ((m_po & ~m_at_next) == '0);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clr_pulse) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:         if (conf_pulse) state_nxt = CHECK;
                CHECK:        state_nxt = (!coord_valid || cell_taken) ? WAIT_RELEASE : COMMIT;
                COMMIT:       state_nxt = all_sunk ? GAME_OVER : WAIT_RELEASE;
                WAIT_RELEASE: if (!db_lvl[0]) state_nxt = IDLE;
                GAME_OVER:    state_nxt = GAME_OVER;
                default:      state_nxt = IDLE;
            endcase
        end
    end

    assign game_over = (state == GAME_OVER);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            coord_q      <= '0;
            m_at_out     <= '0;
            status       <= 2'b00;
            at_wr        <= 1'b0;
            at_idx       <= '0;
            hit_count    <= '0;
            attack_count <= '0;
        end else begin
            at_wr <= 1'b0;
            if (state == IDLE && conf_pulse) coord_q <= coord_at;
            if (clr_pulse) begin
                m_at_out     <= '0;
                status       <= 2'b00;
                at_idx       <= '0;
                hit_count    <= '0;
                attack_count <= '0;
            end else if (state == CHECK && (!coord_valid || cell_taken)) begin
                status <= 2'b11;
            end else if (state == COMMIT) begin
                at_wr        <= 1'b1;
                at_idx       <= cell_idx;
                m_at_out     <= m_at_next;
                attack_count <= (attack_count == CNT_MAX) ? attack_count : attack_count + 6'd1;
                if (cell_hit) begin
                    status    <= 2'b10;
                    hit_count <= (hit_count == CNT_MAX) ? hit_count : hit_count + 6'd1;
                end else begin
                    status <= 2'b01;
                end
            end
        end
    end

endmodule

// File: tb/tb_modulo_controle_ataque.sv
// Bench for modulo_controle_ataque: vector table, corner sequences and random play vs a game-level model.
module tb_modulo_controle_ataque;

    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        clr;
    logic        button_confirmation;
    logic        button_clear;
    logic [5:0]  coord_at;
    logic [34:0] m_po;
    logic [34:0] m_at_out;
    logic [1:0]  status;
    logic        at_wr;
    logic [5:0]  at_idx;
    logic [5:0]  hit_count;
    logic [5:0]  attack_count;
    logic        game_over;

    always #5 clk = ~clk;

    modulo_controle_ataque #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk                 (clk),
        .clr                 (clr),
        .button_confirmation (button_confirmation),
        .button_clear        (button_clear),
        .coord_at            (coord_at),
        .m_po                (m_po),
        .m_at_out            (m_at_out),
        .status              (status),
        .at_wr               (at_wr),
        .at_idx              (at_idx),
        .hit_count           (hit_count),
        .attack_count        (attack_count),
        .game_over           (game_over)
    );

    int         checks   = 0;
    int         failures = 0;
    int         wr_cnt   = 0;
    logic [5:0] wr_idx_seen = '0;

    always @(negedge clk) begin
        if (at_wr === 1'b1) begin
            wr_cnt      = wr_cnt + 1;
            wr_idx_seen = at_idx;
        end
    end

    // Game-level reference: one call per button press.
    bit [34:0] mdl_mat;
    int        mdl_hit, mdl_att, mdl_idx;
    logic [1:0] mdl_st;
    bit        mdl_over, mdl_wr;

    function automatic void mdl_clear();
        mdl_mat  = '0;
        mdl_hit  = 0;
        mdl_att  = 0;
        mdl_st   = 2'b00;
        mdl_over = 1'b0;
        mdl_wr   = 1'b0;
        mdl_idx  = 0;
    endfunction

    function automatic void mdl_press(input logic [5:0] c);
        int line = int'(c[5:3]);
        int col  = int'(c[2:0]);
        int idx;
        mdl_wr = 1'b0;
        if (mdl_over) return;
        if (line < 1 || line > 7 || col < 1 || col > 5) begin
            mdl_st = 2'b11;
            return;
        end
        idx = (line - 1) * 5 + (col - 1);
        if (mdl_mat[34 - idx]) begin
            mdl_st = 2'b11;
            return;
        end
        mdl_wr = 1'b1;
        mdl_idx = idx;
        mdl_mat[34 - idx] = 1'b1;
        if (mdl_att < 35) mdl_att++;
        if (m_po[34 - idx]) begin
            mdl_st = 2'b10;
            if (mdl_hit < 35) mdl_hit++;
        end else begin
            mdl_st = 2'b01;
        end
        mdl_over = (m_po != '0) && ((m_po & ~mdl_mat) == '0);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds confirm, scrambles coord_at once the FSM has left IDLE, then releases.
    task automatic press(input logic [5:0] c, input int hold);
        coord_at = c;
        button_confirmation = 1'b1;
        tick(DEB + 10);
        coord_at = 6'($urandom);
        tick(hold - (DEB + 10));
        button_confirmation = 1'b0;
        tick(DEB + 8);
    endtask

    task automatic compare_model(input string tag, input int w0);
        check({tag, ".m_at"},   64'(m_at_out),     64'(mdl_mat));
        check({tag, ".status"}, 64'(status),       64'(mdl_st));
        check({tag, ".hits"},   64'(hit_count),    64'(mdl_hit));
        check({tag, ".atks"},   64'(attack_count), 64'(mdl_att));
        check({tag, ".over"},   64'(game_over),    64'(mdl_over));
        check({tag, ".wr"},     64'(wr_cnt - w0),  64'(mdl_wr ? 1 : 0));
        if (mdl_wr) check({tag, ".idx"}, 64'(wr_idx_seen), 64'(mdl_idx));
    endtask

    task automatic do_attack(input string tag, input logic [5:0] c, input int hold);
        int w0 = wr_cnt;
        mdl_press(c);
        press(c, hold);
        compare_model(tag, w0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".m_at"},   64'(m_at_out),     64'd0);
        check({tag, ".status"}, 64'(status),       64'd0);
        check({tag, ".at_wr"},  64'(at_wr),        64'd0);
        check({tag, ".at_idx"}, 64'(at_idx),       64'd0);
        check({tag, ".hits"},   64'(hit_count),    64'd0);
        check({tag, ".atks"},   64'(attack_count), 64'd0);
        check({tag, ".over"},   64'(game_over),    64'd0);
    endtask

    task automatic do_clear();
        button_clear = 1'b1;
        tick(DEB + 6);
        button_clear = 1'b0;
        tick(DEB + 6);
        mdl_clear();
    endtask

    typedef struct {
        logic [5:0] coord;
        logic [1:0] st;
        bit         wr;
        int         idx;
        int         att;
        int         hit;
        bit         over;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        logic [5:0] c;

        tbl[0] = '{6'b001_001, 2'b01, 1'b1, 0,  1, 0, 1'b0};
        tbl[1] = '{6'b111_101, 2'b10, 1'b1, 34, 2, 1, 1'b0};
        tbl[2] = '{6'b000_011, 2'b11, 1'b0, 0,  2, 1, 1'b0};
        tbl[3] = '{6'b001_001, 2'b11, 1'b0, 0,  2, 1, 1'b0};
        tbl[4] = '{6'b011_110, 2'b11, 1'b0, 0,  2, 1, 1'b0};
        tbl[5] = '{6'b100_011, 2'b01, 1'b1, 17, 3, 1, 1'b0};
        tbl[6] = '{6'b111_100, 2'b10, 1'b1, 33, 4, 2, 1'b1};
        tbl[7] = '{6'b010_010, 2'b10, 1'b0, 0,  4, 2, 1'b1};

        clr = 1'b0;
        button_confirmation = 1'b0;
        button_clear = 1'b0;
        coord_at = '0;
        m_po = '0;
        mdl_clear();
        #22;
        check_zero("reset");
        @(posedge clk);
        #1;
        clr = 1'b1;
        tick(3);

        // Two ship cells (indices 34 and 33); the table walks to game over.
        m_po = 35'h3;
        for (int i = 0; i < 8; i++) begin
            w0 = wr_cnt;
            mdl_press(tbl[i].coord);
            press(tbl[i].coord, 24);
            check($sformatf("vec%0d.status", i), 64'(status),       64'(tbl[i].st));
            check($sformatf("vec%0d.wr", i),     64'(wr_cnt - w0),  64'(tbl[i].wr));
            if (tbl[i].wr) check($sformatf("vec%0d.idx", i), 64'(wr_idx_seen), 64'(tbl[i].idx));
            check($sformatf("vec%0d.atks", i),   64'(attack_count), 64'(tbl[i].att));
            check($sformatf("vec%0d.hits", i),   64'(hit_count),    64'(tbl[i].hit));
            check($sformatf("vec%0d.over", i),   64'(game_over),    64'(tbl[i].over));
            check($sformatf("vec%0d.m_at", i),   64'(m_at_out),     64'(mdl_mat));
        end

        do_clear();
        check_zero("clear_after_over");
        m_po = '0;
        do_attack("post_clear", 6'b010_011, 24);

        // Bounce shorter than the debounce window, then a long steady hold.
        do_clear();
        w0 = wr_cnt;
        coord_at = 6'b011_100;
        for (int i = 0; i < 12; i++) begin
            button_confirmation = 1'b1;
            tick($urandom_range(1, DEB - 2));
            button_confirmation = 1'b0;
            tick($urandom_range(1, DEB - 2));
        end
        check("bounce.no_commit", 64'(wr_cnt - w0), 64'd0);
        mdl_press(6'b011_100);
        button_confirmation = 1'b1;
        tick(200);
        check("bounce.held_one_commit", 64'(wr_cnt - w0), 64'd1);
        button_confirmation = 1'b0;
        tick(DEB + 8);
        compare_model("bounce", w0);

        // Reset while the FSM sits in COMMIT.
        do_clear();
        w0 = wr_cnt;
        coord_at = 6'b101_010;
        button_confirmation = 1'b1;
        tick(DEB + 4);
        clr = 1'b0;
        button_confirmation = 1'b0;
        tick(1);
        check("rst_commit.in_reset_m_at", 64'(m_at_out), 64'd0);
        check("rst_commit.in_reset_atks", 64'(attack_count), 64'd0);
        tick(2);
        clr = 1'b1;
        tick(DEB + 8);
        check_zero("rst_commit");
        check("rst_commit.wr", 64'(wr_cnt - w0), 64'd0);
        mdl_clear();
        do_attack("rst_resume", 6'b101_010, 24);

        // Random play over two sparse fleets.
        for (int r = 0; r < 2; r++) begin
            do_clear();
            m_po = 35'({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
            for (int i = 0; i < 22; i++) begin
                if (m_po != '0 && $urandom_range(0, 2) == 0) begin
                    int b;
                    int idx;
                    do b = $urandom_range(0, 34); while (!m_po[b]);
                    idx = 34 - b;
                    c = {3'(idx / 5 + 1), 3'(idx % 5 + 1)};
                end else begin
                    c = 6'($urandom);
                end
                do_attack($sformatf("rnd%0d_%0d", r, i), c, $urandom_range(20, 40));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
